// File: rtl/maze_nav_controller.sv
// maze_nav_controller: button-driven character moves, viewport scrolling and win detection for the maze renderer.
// Optional MAZE_NAV_MOVE_COUNT_EN builds a saturating move counter; otherwise move_count is tied to zero.
module maze_nav_controller #(
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [4095:0] path_data,
  input  logic [6:0]    maze_width,
  input  logic [6:0]    maze_height,
  input  logic [6:0]    tile_width,
  input  logic [6:0]    tile_height,
  input  logic [6:0]    start_x,
  input  logic [6:0]    start_y,
  input  logic [6:0]    goal_x,
  input  logic [6:0]    goal_y,
  output logic          enable,
  output logic [6:0]    char_x,
  output logic [6:0]    char_y,
  output logic [6:0]    x_coord,
  output logic [6:0]    y_coord,
  output logic          won,
  output logic          bump,
  output logic [15:0]   move_count
);
  localparam int TW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [TW-1:0] R_LAST = TW'(REPEAT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PLACE, PLAY, CHECK, MOVE, SCROLL, WIN} state_t;
  state_t state;
  logic [6:0] mw, mh, tw, th, gx, gy, tx, ty, ox, oy;
  logic [7:0] vw, vh;
  logic [3:0] btn, btn_q;
  logic [1:0] dir, sel;
  logic [TW-1:0] timer;
  logic held, rise, rep, reject;
  function automatic logic [7:0] view(input int scr, input logic [6:0] sh);
    int w;
    w = scr >> sh;
    return (w > 64) ? 8'd64 : w[7:0];
  endfunction
  // Centre the character, clamped so the view never leaves the maze.
  function automatic logic [6:0] origin(input logic [6:0] c, input logic [6:0] m, input logic [7:0] v);
    logic signed [7:0] d, lim;
    d = $signed({1'b0, c}) - $signed({1'b0, v[7:1]});
    lim = $signed({1'b0, m}) - $signed(v);
    return ({1'b0, m} <= v) ? 7'd0 : d[7] ? 7'd0 : (d > lim) ? lim[6:0] : d[6:0];
  endfunction
  assign btn = {btn_up, btn_down, btn_left, btn_right};
  assign held = |btn;
  assign rise = |(btn & ~btn_q);
  assign rep = held && timer == R_LAST;
  assign vw = view(SCREEN_W, tw);
  assign vh = view(SCREEN_H, th);
  assign ox = origin(char_x, mw, vw);
  assign oy = origin(char_y, mh, vh);
  always_comb begin
    sel = btn_up ? 2'd0 : btn_down ? 2'd1 : btn_left ? 2'd2 : 2'd3;
    tx = (dir == 2'd2) ? char_x - 7'd1 : (dir == 2'd3) ? char_x + 7'd1 : char_x;
    ty = (dir == 2'd0) ? char_y - 7'd1 : (dir == 2'd1) ? char_y + 7'd1 : char_y;
    reject = (dir == 2'd0 && char_y == 7'd0) || (dir == 2'd2 && char_x == 7'd0) ||
             tx >= mw || ty >= mh || !path_data[{ty[5:0], tx[5:0]}];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      enable <= 1'b0;
      char_x <= '0;
      char_y <= '0;
      x_coord <= '0;
      y_coord <= '0;
      won <= 1'b0;
      bump <= 1'b0;
      timer <= '0;
      btn_q <= '0;
      dir <= '0;
      mw <= '0;
      mh <= '0;
      tw <= '0;
      th <= '0;
      gx <= '0;
      gy <= '0;
    end else begin
      btn_q <= btn;
      timer <= (!held || (state == PLAY && (rise || rep))) ? '0 : (timer == R_LAST) ? timer : timer + 1'b1;
      bump <= 1'b0;
      if (start) state <= PLACE;
      else case (state)
        PLACE: begin
          mw <= maze_width;
          mh <= maze_height;
          tw <= tile_width;
          th <= tile_height;
          gx <= goal_x;
          gy <= goal_y;
          char_x <= start_x;
          char_y <= start_y;
          won <= 1'b0;
          state <= SCROLL;
        end
        PLAY: if (rise || rep) begin
          dir <= sel;
          state <= CHECK;
        end
        CHECK: begin
          bump <= reject;
          state <= reject ? PLAY : MOVE;
        end
        MOVE: begin
          char_x <= tx;
          char_y <= ty;
          state <= SCROLL;
        end
        SCROLL: begin
          x_coord <= ox;
          y_coord <= oy;
          enable <= 1'b1;
          won <= {char_x, char_y} == {gx, gy};
          state <= ({char_x, char_y} == {gx, gy}) ? WIN : PLAY;
        end
        default: state <= state;
      endcase
    end
  end
`ifdef MAZE_NAV_MOVE_COUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (state == PLACE) cnt <= '0;
    else if (state == MOVE && !start && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign move_count = cnt;
`else
  assign move_count = 16'h0000;
`endif
endmodule

// File: doc/maze_nav_controller.md
Name: maze_nav_controller

Overview:
- Sequences the maze renderer. Owns character position (char_x/char_y), the scrolled viewport origin (x_coord/y_coord) and the renderer enable.
- Turns directional button input into legal moves, checked against path_data, and detects arrival at the goal tile.
- Sits between the debounced button logic and the renderer; path_data and maze geometry come from the maze generator.

Parameters:
- REPEAT_CYCLES, 12_500_000, cycles between auto-repeat moves while a direction stays held (250 ms at 50 MHz).
- SCREEN_W, 640, visible pixel width.
- SCREEN_H, 480, visible pixel height.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle pulse; (re)starts a game.
- btn_up, btn_down, btn_left, btn_right  input  1 each  debounced levels, 1 = held.
- path_data  input  4096  bit (x + 64*y) = 1 means tile is open.
- maze_width, maze_height  input  7 each  maze size in tiles, 1..64.
- tile_width, tile_height  input  7 each  log2 of tile pixel size, 2..6.
- start_x, start_y, goal_x, goal_y  input  7 each  tile coordinates.
- enable  output  1  renderer enable.
- char_x, char_y  output  7 each  character tile.
- x_coord, y_coord  output  7 each  viewport origin tile.
- won  output  1  level, goal reached.
- bump  output  1  one-cycle pulse, move rejected.
- move_count  output  16  accepted moves (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; enable, char_x, char_y, x_coord, y_coord, won, bump and move_count all 0; repeat timer 0.
- IDLE: enable=0. start -> PLACE.
- PLACE (1 cycle):
  - Latch maze_width/height, tile_width/height and goal into internal registers. Input changes after this are ignored until the next PLACE.
  - char <= start. won <= 0. move_count <= 0.
  - -> SCROLL.
- PLAY: enable=1.
  - Direction select: rising edge of any button, or (some button held and repeat timer == REPEAT_CYCLES-1).
  - Priority when several buttons are set: up > down > left > right.
  - A rising edge reloads the repeat timer to 0. The timer counts only while a button is held, wraps to 0 after a repeat move, and clears when all buttons are released.
  - Latch the selected direction, then -> CHECK.
- CHECK (1 cycle): target = char ± 1 on one axis. Reject if any of:
  - left/up issued at coordinate 0;
  - target_x >= maze_width or target_y >= maze_height;
  - path_data[target_x + 64*target_y] == 0.
  - Reject: bump=1 for this cycle, -> PLAY.
  - Accept: -> MOVE.
- MOVE (1 cycle): char <= target; move_count increments. -> SCROLL.
- SCROLL (1 cycle):
  - view_w = min(SCREEN_W >> tile_width, 64); view_h = min(SCREEN_H >> tile_height, 64).
  - If maze_width <= view_w: x_coord <= 0. Otherwise x_coord <= clamp(char_x - view_w/2, 0, maze_width - view_w), computed signed at 8 bits.
  - y_coord uses the same rule with the y inputs.
  - If char == goal: -> WIN, else -> PLAY.
- Latency: button edge sampled in PLAY at cycle N; char updates at N+2; x_coord/y_coord update at N+3. A further move cannot start before N+4.
- WIN: enable=1, won=1; buttons ignored. start -> PLACE.
- start in any state other than IDLE or WIN: -> PLACE next cycle. An in-flight move is discarded.
- start_x/start_y equal to goal: the FSM passes through PLACE and SCROLL, then enters WIN immediately.

Optional Feature:
- Macro: MAZE_NAV_MOVE_COUNT_EN.
- Defined: move_count is a 16-bit counter. It saturates at 16'hFFFF, clears in PLACE and freezes in WIN.
- Undefined: no counter register is built and move_count is tied to 16'h0000.

Test Plan:
- Reset mid-game: release reset (reset 0->1), pulse start with start=(0,0), maze 8x8, tile_width=tile_height=5. -> char=(0,0), x_coord=y_coord=0 and enable=1 after 2 cycles; asserting reset=0 mid-move returns all outputs to 0 immediately.
- Wall and edge rejection: open tiles (0,0),(1,0) only; press right -> char=(1,0) 2 cycles after the edge. Press right again -> bump pulses 1 cycle, char stays (1,0). Press up at y=0 -> bump, char unchanged.
- Scrolling: 64x64 maze, tile_width=tile_height=4 (view 40x30), fully open. Walk right from (0,0) to (30,0) -> x_coord=10. Continue to (63,0) -> x_coord clamps at 24.
- Auto-repeat: REPEAT_CYCLES=4, hold right for 13 cycles in an open row -> exactly 4 accepted moves (1 on the edge + 3 repeats). With up and right held together -> only y changes.
- Win and restart: goal=(2,0), move right twice -> won=1; further presses are ignored. Pulse start -> won=0, char=start.
- Move counter: with MAZE_NAV_MOVE_COUNT_EN defined, 3 accepted moves plus 2 bumps -> move_count=3. With the macro undefined, move_count stays 0 throughout.
